core_arf_dbg: RTL and testbench

Debug-side master for the architectural register file. It accepts console/front-panel commands (read one register, write one register, dump all 16, clear all 16) over a valid/ready command channel. It performs them through one ARF read port and one ARF write port, and returns results over a valid/ready response channel. It sits beside the pipeline and owns one `core_arf_r` and one `core_arf_w` port. It touches the ARF only while the core reports halted, so its writes never coincide with pipeline writeback.

---
 rtl/core_arf_dbg.sv | 145 ++++++++++++++
 tb/tb_core_arf_dbg.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_arf_dbg.sv
// rtl/core_arf_dbg.sv - debug-side ARF master: serializes READ/WRITE/DUMP/CLEAR console commands
// ARF ports are flattened: arf_r_* is the core_arf_r master, arf_w_* is the core_arf_w master.
module core_arf_dbg (
  input  logic        clk_i,
  input  logic        arst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [3:0]  cmd_addr_i,
  input  logic [15:0] cmd_data_i,
  input  logic        core_halted_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [3:0]  rsp_addr_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_last_o,
  output logic        busy_o,
  output logic [3:0]  arf_r_addr_o,
  input  logic [15:0] arf_r_data_i,
  output logic        arf_w_en_o,
  output logic [3:0]  arf_w_addr_o,
  output logic [15:0] arf_w_data_o
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD, S_WR, S_RSP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic [3:0]  r_ptr;
  logic [15:0] r_wdata;
  logic [3:0]  r_rsp_addr;
  logic [15:0] r_rsp_data;
  logic        r_rsp_last;
  logic        w_op_is_rd;

  // READ and DUMP both have op bit 0 clear; they go through RD, the others through WR
  assign w_op_is_rd = ~r_op[0];

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    arf_w_en_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (!core_halted_i)   w_next = S_WAIT;
          else if (!cmd_op_i[0]) w_next = S_RD;
          else                  w_next = S_WR;
        end
      end
      S_WAIT: begin
        if (core_halted_i) w_next = w_op_is_rd ? S_RD : S_WR;
      end
      S_RD: begin
        w_next = core_halted_i ? S_RSP : S_WAIT;
      end
      S_WR: begin
        // a halt drop parks here with the write strobe low and ptr frozen
        if (core_halted_i) begin
          arf_w_en_o = 1'b1;
          if (r_op == OP_WRITE || r_ptr == 4'hF) w_next = S_RSP;
        end
      end
      S_RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          if (r_rsp_last)         w_next = S_IDLE;
          else if (core_halted_i) w_next = S_RD;
          else                    w_next = S_WAIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_op       <= 2'b00;
      r_ptr      <= 4'd0;
      r_wdata    <= 16'd0;
      r_rsp_addr <= 4'd0;
      r_rsp_data <= 16'd0;
      r_rsp_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_op    <= cmd_op_i;
            r_wdata <= cmd_data_i;
            r_ptr   <= cmd_op_i[1] ? 4'd0 : cmd_addr_i;
          end
        end
        S_RD: begin
          if (core_halted_i) begin
            r_rsp_addr <= r_ptr;
            r_rsp_data <= arf_r_data_i;
            r_rsp_last <= (r_op == OP_READ) || (r_ptr == 4'hF);
          end
        end
        S_WR: begin
          if (core_halted_i) begin
            if (r_op == OP_WRITE) begin
              r_rsp_addr <= r_ptr;
              r_rsp_data <= r_wdata;
              r_rsp_last <= 1'b1;
            end else if (r_ptr != 4'hF) begin
              r_ptr <= r_ptr + 4'd1;
            end else begin
              r_rsp_addr <= 4'hF;
              r_rsp_data <= 16'd0;
              r_rsp_last <= 1'b1;
            end
          end
        end
        S_RSP: begin
          if (rsp_ready_i && !r_rsp_last) r_ptr <= r_ptr + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = (r_state != S_IDLE);
  assign rsp_addr_o   = r_rsp_addr;
  assign rsp_data_o   = r_rsp_data;
  assign rsp_last_o   = r_rsp_last;
  assign arf_r_addr_o = r_ptr;
  assign arf_w_addr_o = arf_w_en_o ? r_ptr : 4'd0;
  assign arf_w_data_o = (arf_w_en_o && r_op == OP_WRITE) ? r_wdata : 16'd0;

endmodule

// File: tb/tb_core_arf_dbg.sv
// tb/tb_core_arf_dbg.sv - directed bench for core_arf_dbg with a behavioural 16x16 ARF
module tb_core_arf_dbg;

  logic        clk = 1'b0;
  logic        arst_ni = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_addr = 4'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        core_halted = 1'b1;
  logic        rsp_valid_o;
  logic        rsp_ready = 1'b1;
  logic [3:0]  rsp_addr_o;
  logic [15:0] rsp_data_o;
  logic        rsp_last_o;
  logic        busy_o;
  logic [3:0]  arf_r_addr_o;
  logic [15:0] arf_r_data;
  logic        arf_w_en_o;
  logic [3:0]  arf_w_addr_o;
  logic [15:0] arf_w_data_o;

  logic [15:0] mem [16];
  logic [3:0]  wl_addr [$];
  logic [15:0] wl_data [$];
  logic [3:0]  q_addr [$];
  logic [15:0] q_data [$];
  logic        q_last [$];

  int vectors = 0;
  int miscompares = 0;
  int mon_fails = 0;

  core_arf_dbg dut (
    .clk_i         (clk),
    .arst_ni       (arst_ni),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_op_i      (cmd_op),
    .cmd_addr_i    (cmd_addr),
    .cmd_data_i    (cmd_data),
    .core_halted_i (core_halted),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready),
    .rsp_addr_o    (rsp_addr_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_last_o    (rsp_last_o),
    .busy_o        (busy_o),
    .arf_r_addr_o  (arf_r_addr_o),
    .arf_r_data_i  (arf_r_data),
    .arf_w_en_o    (arf_w_en_o),
    .arf_w_addr_o  (arf_w_addr_o),
    .arf_w_data_o  (arf_w_data_o)
  );

  always #5 clk = ~clk;

  assign arf_r_data = mem[arf_r_addr_o];

  always @(posedge clk) begin
    if (arf_w_en_o) begin
      mem[arf_w_addr_o] <= arf_w_data_o;
      wl_addr.push_back(arf_w_addr_o);
      wl_data.push_back(arf_w_data_o);
    end
  end

  always @(negedge clk) begin
    if (arst_ni) begin
      assert (!arf_w_en_o || core_halted) else begin
        mon_fails++;
        $error("FAIL en_while_running: observed en=%0b halted=%0b", arf_w_en_o, core_halted);
      end
      assert (!(cmd_ready_o && rsp_valid_o)) else begin
        mon_fails++;
        $error("FAIL ready_valid_overlap: observed cmd_ready=%0b rsp_valid=%0b", cmd_ready_o, rsp_valid_o);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_rsp_addr"},  32'(rsp_addr_o),  32'd0);
    check({tag, "_rsp_data"},  32'(rsp_data_o),  32'd0);
    check({tag, "_rsp_last"},  32'(rsp_last_o),  32'd0);
    check({tag, "_busy"},      32'(busy_o),      32'd0);
    check({tag, "_w_en"},      32'(arf_w_en_o),  32'd0);
    check({tag, "_w_addr"},    32'(arf_w_addr_o), 32'd0);
    check({tag, "_w_data"},    32'(arf_w_data_o), 32'd0);
  endtask

  // Issues one command from IDLE and gathers responses until rsp_last, optionally throttling rsp_ready.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data,
                         input bit toggle, input int max_cycles);
    bit          done = 0;
    bit          held = 0;
    logic [3:0]  h_addr = 4'd0;
    logic [15:0] h_data = 16'd0;
    logic        h_last = 1'b0;
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    for (int c = 0; c < max_cycles && !done; c++) begin
      rsp_ready = toggle ? c[0] : 1'b1;
      @(negedge clk);
      if (held) begin
        check("hold_stable", {11'd0, rsp_valid_o, rsp_addr_o, rsp_data_o},
              {11'd0, 1'b1, h_addr, h_data});
        check("hold_last", 32'(rsp_last_o), 32'(h_last));
        held = 0;
      end
      if (rsp_valid_o && !rsp_ready) begin
        held = 1;
        h_addr = rsp_addr_o;
        h_data = rsp_data_o;
        h_last = rsp_last_o;
      end
      if (rsp_valid_o && rsp_ready) begin
        q_addr.push_back(rsp_addr_o);
        q_data.push_back(rsp_data_o);
        q_last.push_back(rsp_last_o);
        if (rsp_last_o) done = 1;
      end
      step();
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    check("cmd_completed", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          nw;
    int          start;
    int          nrsp;
    bit          dropped;
    bit          done;
    bit          saw_valid;

    // ---- reset ----
    #3 arst_ni = 1'b0;
    #1 check_reset_outputs("reset");
    step();
    step();
    arst_ni = 1'b1;
    step();

    // ---- WRITE R5=0xBEEF then READ R5, cycle-exact ----
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd5; cmd_data = 16'hBEEF;
    start = wl_addr.size();
    @(negedge clk);
    check("wr_c0_ready", 32'(cmd_ready_o), 32'd1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("wr_c1_en",   32'(arf_w_en_o),   32'd1);
    check("wr_c1_addr", 32'(arf_w_addr_o), 32'd5);
    check("wr_c1_data", 32'(arf_w_data_o), 32'hBEEF);
    check("wr_c1_busy", 32'(busy_o),       32'd1);
    step();
    @(negedge clk);
    check("wr_c2_rsp", {11'd0, rsp_valid_o, rsp_addr_o, rsp_data_o}, {11'd0, 1'b1, 4'd5, 16'hBEEF});
    check("wr_c2_last", 32'(rsp_last_o), 32'd1);
    check("wr_c2_en",   32'(arf_w_en_o), 32'd0);
    step();
    check("wr_one_pulse", 32'(wl_addr.size() - start), 32'd1);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'd5;
    @(negedge clk);
    check("rd_c3_ready", 32'(cmd_ready_o), 32'd1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rd_c4_valid", 32'(rsp_valid_o),  32'd0);
    check("rd_c4_raddr", 32'(arf_r_addr_o), 32'd5);
    step();
    @(negedge clk);
    check("rd_c5_rsp", {11'd0, rsp_valid_o, rsp_addr_o, rsp_data_o}, {11'd0, 1'b1, 4'd5, 16'hBEEF});
    check("rd_c5_last", 32'(rsp_last_o), 32'd1);
    step();
    @(negedge clk);
    check("rd_c6_idle", 32'(cmd_ready_o), 32'd1);
    step();

    // ---- preload Rn=0x1000+n, then DUMP with throttled rsp_ready ----
    for (int n = 0; n < 16; n++) run_cmd(2'b01, 4'(n), 16'h1000 + 16'(n), 1'b0, 10);
    run_cmd(2'b10, 4'd0, 16'd0, 1'b1, 200);
    check("dump_count", 32'(q_addr.size()), 32'd16);
    for (int n = 0; n < 16 && n < q_addr.size(); n++) begin
      check("dump_word", {11'd0, q_last[n], q_addr[n], q_data[n]},
            {11'd0, (n == 15), 4'(n), 16'h1000 + 16'(n)});
    end

    // ---- CLEAR with halted dropped for 3 cycles after the 6th write ----
    start = wl_addr.size();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 4'd9;
    step();
    cmd_valid = 1'b0;
    nw = 0; dropped = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (arf_w_en_o) nw++;
      if (rsp_valid_o) begin
        check("clr_rsp", {11'd0, rsp_last_o, rsp_addr_o, rsp_data_o}, {11'd0, 1'b1, 4'hF, 16'd0});
        done = 1;
      end
      step();
      if (nw == 6 && !dropped) begin
        dropped = 1;
        core_halted = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("clr_drop_en",   32'(arf_w_en_o), 32'd0);
          check("clr_drop_busy", 32'(busy_o),     32'd1);
          step();
        end
        core_halted = 1'b1;
      end
    end
    check("clr_done", 32'(done), 32'd1);
    check("clr_writes", 32'(wl_addr.size() - start), 32'd16);
    for (int n = 0; n < 16 && start + n < wl_addr.size(); n++) begin
      check("clr_write_seq", {12'd0, wl_addr[start + n], wl_data[start + n]}, {12'd0, 4'(n), 16'd0});
    end
    run_cmd(2'b10, 4'd3, 16'd0, 1'b0, 100);
    check("dump0_count", 32'(q_addr.size()), 32'd16);
    for (int n = 0; n < 16 && n < q_addr.size(); n++) begin
      check("dump0_word", {11'd0, q_last[n], q_addr[n], q_data[n]}, {11'd0, (n == 15), 4'(n), 16'd0});
    end

    // ---- WRITE R7=0x1234 issued while running for 10 cycles ----
    start = wl_addr.size();
    core_halted = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd7; cmd_data = 16'h1234;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("wait_busy", {30'd0, busy_o, arf_w_en_o}, {30'd0, 1'b1, 1'b0});
      step();
    end
    check("wait_no_write", 32'(wl_addr.size() - start), 32'd0);
    core_halted = 1'b1;
    @(negedge clk);
    check("wait_rise_en", 32'(arf_w_en_o), 32'd0);
    step();
    @(negedge clk);
    check("wait_access", {11'd0, arf_w_en_o, arf_w_addr_o, arf_w_data_o}, {11'd0, 1'b1, 4'd7, 16'h1234});
    step();
    @(negedge clk);
    check("wait_rsp", {10'd0, rsp_valid_o, rsp_last_o, rsp_addr_o, rsp_data_o},
          {10'd0, 1'b1, 1'b1, 4'd7, 16'h1234});
    step();
    run_cmd(2'b00, 4'd7, 16'd0, 1'b0, 10);
    check("wait_readback", {12'd0, q_addr[0], q_data[0]}, {12'd0, 4'd7, 16'h1234});

    // ---- reset in the middle of a DUMP after 4 responses ----
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 4'd0;
    nrsp = 0;
    for (int c = 0; c < 40 && nrsp < 4; c++) begin
      @(negedge clk);
      if (rsp_valid_o) nrsp++;
      step();
      cmd_valid = 1'b0;
    end
    check("mid_dump_rsps", 32'(nrsp), 32'd4);
    check("mid_dump_busy", 32'(busy_o), 32'd1);
    arst_ni = 1'b0;
    #1 check_reset_outputs("mid_reset");
    step();
    step();
    arst_ni = 1'b1;
    saw_valid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid_o || busy_o) saw_valid = 1;
      step();
    end
    check("post_reset_quiet", 32'(saw_valid), 32'd0);
    check("post_reset_ready", 32'(cmd_ready_o), 32'd1);
    check("post_reset_ptr_r0", 32'(arf_r_addr_o), 32'd0);

    miscompares = miscompares + mon_fails;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
